// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide sequencer: op codes, FSM states,
// commit modes and the latency counter width.
package mdu_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MTHI  = 4'd5,
        OP_MTLO  = 4'd6,
        OP_MADD  = 4'd7,
        OP_MADDU = 4'd8,
        OP_MSUB  = 4'd9,
        OP_MSUBU = 4'd10
    } mdu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } mdu_state_e;

    // What happens to {hi,lo} when the busy counter expires.
    typedef enum logic [1:0] {
        CM_WRITE = 2'd0,
        CM_KEEP  = 2'd1,
        CM_ADD   = 2'd2,
        CM_SUB   = 2'd3
    } commit_e;

endpackage

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide sequencer owning HI/LO; models latency with a busy counter.
// Define MDU_MADD_EN to decode the MADD/MADDU/MSUB/MSUBU accumulate ops.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRQ,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    commit_e          mode_q, mode_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      temp_hi_q, temp_hi_d, temp_lo_q, temp_lo_d;

    logic [63:0]      prod_s, prod_u;
    logic             div_signed;
    logic [31:0]      a_mag, b_mag, div_n, div_d, mag_q, mag_r, div_q, div_r;
    logic             long_op;
    logic [CNT_W-1:0] load_cnt;
    commit_e          load_mode;
    logic [63:0]      load_res;

    assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign prod_u = {32'd0, a} * {32'd0, b};

    // One unsigned divider serves both DIV and DIVU; signed results are fixed up
    // afterwards so 0x80000000 / -1 wraps to 0x80000000 instead of trapping.
    assign div_signed = (op == OP_DIV);
    assign a_mag      = a[31] ? (~a + 32'd1) : a;
    assign b_mag      = b[31] ? (~b + 32'd1) : b;
    assign div_n      = div_signed ? a_mag : a;
    assign div_d      = div_signed ? b_mag : b;
    assign mag_q      = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
    assign mag_r      = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
    assign div_q      = (div_signed && (a[31] ^ b[31])) ? (~mag_q + 32'd1) : mag_q;
    assign div_r      = (div_signed && a[31]) ? (~mag_r + 32'd1) : mag_r;

    always_comb begin
        long_op   = 1'b0;
        load_cnt  = MULT_N;
        load_mode = CM_WRITE;
        load_res  = prod_s;
        case (op)
            OP_MULT:  long_op = 1'b1;
            OP_MULTU: begin
                long_op  = 1'b1;
                load_res = prod_u;
            end
            OP_DIV, OP_DIVU: begin
                long_op  = 1'b1;
                load_cnt = DIV_N;
                load_res = {div_r, div_q};
                if (b == 32'd0) load_mode = CM_KEEP;
            end
`ifdef MDU_MADD_EN
            OP_MADD: begin
                long_op   = 1'b1;
                load_mode = CM_ADD;
            end
            OP_MADDU: begin
                long_op   = 1'b1;
                load_mode = CM_ADD;
                load_res  = prod_u;
            end
            OP_MSUB: begin
                long_op   = 1'b1;
                load_mode = CM_SUB;
            end
            OP_MSUBU: begin
                long_op   = 1'b1;
                load_mode = CM_SUB;
                load_res  = prod_u;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        temp_hi_d = temp_hi_q;
        temp_lo_d = temp_lo_q;
        case (state_q)
            ST_IDLE: begin
                if (start && !IRQ) begin
                    if (long_op) begin
                        state_d   = ST_BUSY;
                        cnt_d     = load_cnt;
                        mode_d    = load_mode;
                        temp_hi_d = load_res[63:32];
                        temp_lo_d = load_res[31:0];
                    end else if (op == OP_MTHI) begin
                        hi_d = a;
                    end else if (op == OP_MTLO) begin
                        lo_d = a;
                    end
                end
            end
            default: begin
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    case (mode_q)
                        CM_WRITE: {hi_d, lo_d} = {temp_hi_q, temp_lo_q};
                        CM_ADD:   {hi_d, lo_d} = {hi_q, lo_q} + {temp_hi_q, temp_lo_q};
                        CM_SUB:   {hi_d, lo_d} = {hi_q, lo_q} - {temp_hi_q, temp_lo_q};
                        default:  ;
                    endcase
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            mode_q    <= CM_WRITE;
            hi_q      <= '0;
            lo_q      <= '0;
            temp_hi_q <= '0;
            temp_lo_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            temp_hi_q <= temp_hi_d;
            temp_lo_q <= temp_lo_d;
        end
    end

    assign busy      = (state_q == ST_BUSY);
    assign stall_req = busy | (start & long_op);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: a driver pushes expected busy window and HI/LO
// per transaction; a monitor pops and checks them cycle by cycle.
module tb_mdu_ctrl;

    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        IRQ = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int tests = 0;
    int fails = 0;
    int edge_cnt = 0;
    bit mon_active = 1'b0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    typedef struct {
        string       nm;
        int          e0;
        int          nb;
        logic [31:0] ohi, olo, nhi, nlo;
        bit          st_exp, st_act;
    } item_t;

    item_t scb[$];

    mdu_ctrl #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .IRQ(IRQ), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(posedge clk) begin
        if (start && busy && !reset) begin
            tests++;
            fails++;
            $display("FAIL start_while_busy: got start=1 busy=1 required busy=0 at edge %0d", edge_cnt);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: straight arithmetic on 64-bit integers, one whole instruction at a time.
    function automatic void model(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                                  input bit irq, output int nb, output bit st);
        longint sa, sbv, q, r;
        longint unsigned ua, ub, uq, ur;
        logic [63:0] res, acc;
        bit long_op;
        sa = longint'($signed(av));
        sbv = longint'($signed(bv));
        ua = {32'd0, av};
        ub = {32'd0, bv};
        acc = {m_hi, m_lo};
        res = acc;
        long_op = 1'b1;
        nb = MULT_CYCLES;
        case (o)
            4'd1: res = sa * sbv;
            4'd2: res = ua * ub;
            4'd3: begin
                nb = DIV_CYCLES;
                if (bv != 0) begin
                    q = sa / sbv;
                    r = sa % sbv;
                    res = {r[31:0], q[31:0]};
                end
            end
            4'd4: begin
                nb = DIV_CYCLES;
                if (bv != 0) begin
                    uq = ua / ub;
                    ur = ua % ub;
                    res = {ur[31:0], uq[31:0]};
                end
            end
`ifdef MDU_MADD_EN
            4'd7:  res = acc + sa * sbv;
            4'd8:  res = acc + ua * ub;
            4'd9:  res = acc - sa * sbv;
            4'd10: res = acc - ua * ub;
`endif
            default: long_op = 1'b0;
        endcase
        st = long_op;
        if (irq) begin
            nb = 0;
            return;
        end
        if (long_op) begin
            {m_hi, m_lo} = res;
        end else begin
            nb = 0;
            if (o == 4'd5) m_hi = av;
            else if (o == 4'd6) m_lo = av;
        end
    endfunction

    // mode 0: plain, 1: IRQ pulse while busy, 2: reset in the third busy cycle
    task automatic issue(input logic [3:0] o, input logic [31:0] av, input logic [31:0] bv,
                         input bit irq, input int mode, input string nm);
        item_t it;
        int nb;
        bit st;
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = av;
        b = bv;
        IRQ = irq;
        #1;
        it.st_act = stall_req;
        it.nm = nm;
        it.e0 = edge_cnt + 1;
        it.ohi = m_hi;
        it.olo = m_lo;
        model(o, av, bv, irq, nb, st);
        it.st_exp = st;
        if (mode == 2) begin
            nb = 3;
            m_hi = 32'd0;
            m_lo = 32'd0;
        end
        it.nb = nb;
        it.nhi = m_hi;
        it.nlo = m_lo;
        scb.push_back(it);
        @(posedge clk);
        #1;
        start = 1'b0;
        op = 4'd0;
        IRQ = 1'b0;
        for (int k = 0; k < nb; k++) begin
            @(negedge clk);
            if (mode == 1) IRQ = (k == 1);
            if (mode == 2 && k == 2) reset = 1'b1;
        end
        if (mode == 2) begin
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin : monitor
        item_t it;
        forever begin
            if (scb.size() == 0) begin
                @(negedge clk);
            end else begin
                it = scb.pop_front();
                mon_active = 1'b1;
                chk({it.nm, " stall_req"}, {31'd0, it.st_act}, {31'd0, it.st_exp});
                if (edge_cnt > it.e0) chk({it.nm, " order"}, edge_cnt, it.e0);
                while (edge_cnt < it.e0) @(negedge clk);
                for (int k = 0; k <= it.nb; k++) begin
                    if (k > 0) @(negedge clk);
                    if (k < it.nb) begin
                        chk({it.nm, " busy_during"}, {31'd0, busy}, 32'd1);
                        chk({it.nm, " hi_hold"}, hi, it.ohi);
                        chk({it.nm, " lo_hold"}, lo, it.olo);
                    end else begin
                        chk({it.nm, " busy_after"}, {31'd0, busy}, 32'd0);
                        chk({it.nm, " hi"}, hi, it.nhi);
                        chk({it.nm, " lo"}, lo, it.nlo);
                    end
                end
                $display("[TB] %s busy=%0d hi=%h lo=%h", it.nm, it.nb, hi, lo);
                mon_active = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        logic [3:0] o;
        int mode;
        int waited;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        issue(4'd0, 32'd0, 32'd0, 1'b0, 0, "reset_state");
        issue(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0, "mult_neg2x3");
        issue(4'd4, 32'd100, 32'd7, 1'b0, 0, "divu_100_7");
        issue(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0, "div_m7_2");
        issue(4'd5, 32'h1234_5678, 32'd0, 1'b0, 0, "mthi");
        issue(4'd3, 32'd5, 32'd0, 1'b0, 0, "div_by_zero");
        issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0, "div_overflow");
        issue(4'd1, 32'd9, 32'd9, 1'b1, 0, "mult_irq");
        issue(4'd6, 32'd77, 32'd0, 1'b1, 0, "mtlo_irq");
        issue(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1, "multu_irq_mid");
        issue(4'd3, 32'd1000, 32'd3, 1'b0, 2, "div_reset_mid");
        for (int i = 0; i < 12; i++) issue(4'd0, 32'd0, 32'd0, 1'b0, 0, "post_reset_idle");
        issue(4'd5, 32'd0, 32'd0, 1'b0, 0, "mthi_0");
        issue(4'd6, 32'd10, 32'd0, 1'b0, 0, "mtlo_10");
        issue(4'd7, 32'd3, 32'd4, 1'b0, 0, "madd_3x4");
        issue(4'd15, 32'd3, 32'd4, 1'b0, 0, "unknown_op");
        for (int i = 0; i < 150; i++) begin
            o = 4'($urandom_range(0, 11));
            mode = ($urandom_range(0, 4) == 0) ? 1 : 0;
            issue(o, pick(), pick(), ($urandom_range(0, 7) == 0), mode, "random");
        end
        waited = 0;
        while ((scb.size() != 0 || mon_active) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        @(negedge clk);
        if (scb.size() != 0 || mon_active) chk("drain", 32'd1, 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
